// File: rtl/ex_pkg.sv
// Shared types and defaults for the execute stage.
package ex_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_REG_W  = 4;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_XOR = 2'b10,
        ALU_AND = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_MEM  = 2'b01,
        FWD_WB   = 2'b10
    } fwd_sel_e;

    // Add 0..2 to a 16-bit event counter, sticking at all-ones.
    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] inc);
        logic [16:0] sum;
        sum = {1'b0, a} + {15'b0, inc};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

endpackage

// File: rtl/ex_forward_unit.sv
// Combinational RAW-hazard detector: picks MEM, WB or the ID-read value per source operand.
module ex_forward_unit
    import ex_pkg::*;
#(
    parameter int unsigned REG_W = DEF_REG_W
) (
    input  logic [REG_W-1:0] rs1,
    input  logic [REG_W-1:0] rs2,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_reg_write,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             wb_reg_write,
    output fwd_sel_e         sel1,
    output fwd_sel_e         sel2
);

    function automatic fwd_sel_e pick(input logic [REG_W-1:0] rs);
        // r0 is hardwired to zero, so it is never a forwarding target.
        if (rs == '0) begin
            return FWD_NONE;
        end else if (mem_reg_write && (mem_rd == rs)) begin
            return FWD_MEM;
        end else if (wb_reg_write && (wb_rd == rs)) begin
            return FWD_WB;
        end
        return FWD_NONE;
    endfunction

    always_comb begin
        sel1 = pick(rs1);
        sel2 = pick(rs2);
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU and the EX/MEM boundary register.
// Optional forwarding event counters are enabled with `define EX_FWD_CNT_EN.
module ex_stage
    import ex_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned REG_W  = DEF_REG_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              EX_valid,
    input  logic [DATA_W-1:0] EX_data1,
    input  logic [DATA_W-1:0] EX_data2,
    input  logic [DATA_W-1:0] EX_Imm,
    input  logic [REG_W-1:0]  EX_rd,
    input  logic [REG_W-1:0]  EX_rs1,
    input  logic [REG_W-1:0]  EX_rs2,
    input  logic [1:0]        EX_ALUControl,
    input  logic              EX_RegWrite,
    input  logic              EX_MemWrite,
    input  logic              EX_MemToReg,
    input  logic              EX_ALUScr,
    input  logic [REG_W-1:0]  MEM_fwd_rd,
    input  logic              MEM_fwd_RegWrite,
    input  logic [DATA_W-1:0] MEM_fwd_data,
    input  logic [REG_W-1:0]  WB_fwd_rd,
    input  logic              WB_fwd_RegWrite,
    input  logic [DATA_W-1:0] WB_fwd_data,
    input  logic              stall,
    input  logic              flush,
    output logic              MEM_valid,
    output logic [DATA_W-1:0] MEM_ALUResult,
    output logic [DATA_W-1:0] MEM_StoreData,
    output logic [REG_W-1:0]  MEM_rd,
    output logic              MEM_RegWrite,
    output logic              MEM_MemWrite,
    output logic              MEM_MemToReg,
    output logic [15:0]       fwd_mem_cnt,
    output logic [15:0]       fwd_wb_cnt
);

    fwd_sel_e          sel1, sel2;
    logic [DATA_W-1:0] rs1_val, rs2_val, op_b, alu_res;

    ex_forward_unit #(
        .REG_W(REG_W)
    ) u_fwd (
        .rs1          (EX_rs1),
        .rs2          (EX_rs2),
        .mem_rd       (MEM_fwd_rd),
        .mem_reg_write(MEM_fwd_RegWrite),
        .wb_rd        (WB_fwd_rd),
        .wb_reg_write (WB_fwd_RegWrite),
        .sel1         (sel1),
        .sel2         (sel2)
    );

    always_comb begin
        case (sel1)
            FWD_MEM: rs1_val = MEM_fwd_data;
            FWD_WB:  rs1_val = WB_fwd_data;
            default: rs1_val = EX_data1;
        endcase
        case (sel2)
            FWD_MEM: rs2_val = MEM_fwd_data;
            FWD_WB:  rs2_val = WB_fwd_data;
            default: rs2_val = EX_data2;
        endcase
        op_b = EX_ALUScr ? EX_Imm : rs2_val;
        unique case (alu_op_e'(EX_ALUControl))
            ALU_ADD: alu_res = rs1_val + op_b;
            ALU_SUB: alu_res = rs1_val - op_b;
            ALU_XOR: alu_res = rs1_val ^ op_b;
            ALU_AND: alu_res = rs1_val & op_b;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            MEM_valid     <= 1'b0;
            MEM_ALUResult <= '0;
            MEM_StoreData <= '0;
            MEM_rd        <= '0;
            MEM_RegWrite  <= 1'b0;
            MEM_MemWrite  <= 1'b0;
            MEM_MemToReg  <= 1'b0;
        end else if (!stall) begin
            MEM_valid     <= EX_valid;
            MEM_ALUResult <= alu_res;
            MEM_StoreData <= rs2_val;
            MEM_rd        <= EX_rd;
            // An invalid slot must never reach a write port downstream.
            MEM_RegWrite  <= EX_RegWrite & EX_valid;
            MEM_MemWrite  <= EX_MemWrite & EX_valid;
            MEM_MemToReg  <= EX_MemToReg;
        end
    end

`ifdef EX_FWD_CNT_EN
    logic [1:0] mem_inc, wb_inc;

    always_comb begin
        mem_inc = 2'(sel1 == FWD_MEM) + 2'(sel2 == FWD_MEM);
        wb_inc  = 2'(sel1 == FWD_WB) + 2'(sel2 == FWD_WB);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_mem_cnt <= '0;
            fwd_wb_cnt  <= '0;
        end else if (!flush && !stall && EX_valid) begin
            fwd_mem_cnt <= sat_add16(fwd_mem_cnt, mem_inc);
            fwd_wb_cnt  <= sat_add16(fwd_wb_cnt, wb_inc);
        end
    end
`else
    assign fwd_mem_cnt = '0;
    assign fwd_wb_cnt  = '0;
`endif

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed scenarios plus randomized traffic vs. a reference model.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        EX_valid;
    logic [31:0] EX_data1, EX_data2, EX_Imm;
    logic [3:0]  EX_rd, EX_rs1, EX_rs2;
    logic [1:0]  EX_ALUControl;
    logic        EX_RegWrite, EX_MemWrite, EX_MemToReg, EX_ALUScr;
    logic [3:0]  MEM_fwd_rd, WB_fwd_rd;
    logic        MEM_fwd_RegWrite, WB_fwd_RegWrite;
    logic [31:0] MEM_fwd_data, WB_fwd_data;
    logic        stall, flush;

    logic        MEM_valid, MEM_RegWrite, MEM_MemWrite, MEM_MemToReg;
    logic [31:0] MEM_ALUResult, MEM_StoreData;
    logic [3:0]  MEM_rd;
    logic [15:0] fwd_mem_cnt, fwd_wb_cnt;

    ex_stage dut (
        .clk             (clk),
        .rst             (rst),
        .EX_valid        (EX_valid),
        .EX_data1        (EX_data1),
        .EX_data2        (EX_data2),
        .EX_Imm          (EX_Imm),
        .EX_rd           (EX_rd),
        .EX_rs1          (EX_rs1),
        .EX_rs2          (EX_rs2),
        .EX_ALUControl   (EX_ALUControl),
        .EX_RegWrite     (EX_RegWrite),
        .EX_MemWrite     (EX_MemWrite),
        .EX_MemToReg     (EX_MemToReg),
        .EX_ALUScr       (EX_ALUScr),
        .MEM_fwd_rd      (MEM_fwd_rd),
        .MEM_fwd_RegWrite(MEM_fwd_RegWrite),
        .MEM_fwd_data    (MEM_fwd_data),
        .WB_fwd_rd       (WB_fwd_rd),
        .WB_fwd_RegWrite (WB_fwd_RegWrite),
        .WB_fwd_data     (WB_fwd_data),
        .stall           (stall),
        .flush           (flush),
        .MEM_valid       (MEM_valid),
        .MEM_ALUResult   (MEM_ALUResult),
        .MEM_StoreData   (MEM_StoreData),
        .MEM_rd          (MEM_rd),
        .MEM_RegWrite    (MEM_RegWrite),
        .MEM_MemWrite    (MEM_MemWrite),
        .MEM_MemToReg    (MEM_MemToReg),
        .fwd_mem_cnt     (fwd_mem_cnt),
        .fwd_wb_cnt      (fwd_wb_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model of the EX/MEM boundary contents.
    logic        m_valid, m_rw, m_mw, m_mtr;
    logic [31:0] m_res, m_sd;
    logic [3:0]  m_rd;
    int          m_cmem, m_cwb;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // 0 = register file value, 1 = from MEM, 2 = from WB
    function automatic int source_of(input logic [3:0] rs);
        if (rs == 0) return 0;
        if (MEM_fwd_RegWrite && MEM_fwd_rd == rs) return 1;
        if (WB_fwd_RegWrite && WB_fwd_rd == rs) return 2;
        return 0;
    endfunction

    function automatic logic [31:0] value_of(input logic [3:0] rs, input logic [31:0] rf);
        int s;
        s = source_of(rs);
        return (s == 1) ? MEM_fwd_data : (s == 2) ? WB_fwd_data : rf;
    endfunction

    task automatic model_update();
        logic [31:0] a, b, st, r;
        int          n_mem, n_wb;
        a  = value_of(EX_rs1, EX_data1);
        st = value_of(EX_rs2, EX_data2);
        b  = EX_ALUScr ? EX_Imm : st;
        case (EX_ALUControl)
            2'd0:    r = a + b;
            2'd1:    r = a - b;
            2'd2:    r = a ^ b;
            default: r = a & b;
        endcase
        n_mem = int'(source_of(EX_rs1) == 1) + int'(source_of(EX_rs2) == 1);
        n_wb  = int'(source_of(EX_rs1) == 2) + int'(source_of(EX_rs2) == 2);
        if (rst || flush) begin
            {m_valid, m_rw, m_mw, m_mtr} = 4'b0;
            m_res = 0; m_sd = 0; m_rd = 0;
            if (rst) begin
                m_cmem = 0;
                m_cwb  = 0;
            end
        end else if (!stall) begin
            m_valid = EX_valid;
            m_res   = r;
            m_sd    = st;
            m_rd    = EX_rd;
            m_rw    = EX_RegWrite && EX_valid;
            m_mw    = EX_MemWrite && EX_valid;
            m_mtr   = EX_MemToReg;
`ifdef EX_FWD_CNT_EN
            if (EX_valid) begin
                m_cmem = (m_cmem + n_mem > 65535) ? 65535 : m_cmem + n_mem;
                m_cwb  = (m_cwb + n_wb > 65535) ? 65535 : m_cwb + n_wb;
            end
`else
            if (n_mem + n_wb < 0) m_cmem = 0;
`endif
        end
    endtask

    task automatic compare();
        chk("valid", 32'(MEM_valid), 32'(m_valid));
        chk("alu_result", MEM_ALUResult, m_res);
        chk("store_data", MEM_StoreData, m_sd);
        chk("rd", 32'(MEM_rd), 32'(m_rd));
        chk("reg_write", 32'(MEM_RegWrite), 32'(m_rw));
        chk("mem_write", 32'(MEM_MemWrite), 32'(m_mw));
        chk("mem_to_reg", 32'(MEM_MemToReg), 32'(m_mtr));
        chk("fwd_mem_cnt", 32'(fwd_mem_cnt), 32'(m_cmem));
        chk("fwd_wb_cnt", 32'(fwd_wb_cnt), 32'(m_cwb));
    endtask

    // Inputs are set at a negedge; step applies one posedge and checks at the next negedge.
    task automatic step();
        model_update();
        @(negedge clk);
        compare();
    endtask

    task automatic idle();
        rst = 0; stall = 0; flush = 0;
        EX_valid = 0; EX_data1 = 0; EX_data2 = 0; EX_Imm = 0;
        EX_rd = 0; EX_rs1 = 0; EX_rs2 = 0; EX_ALUControl = 0;
        EX_RegWrite = 0; EX_MemWrite = 0; EX_MemToReg = 0; EX_ALUScr = 0;
        MEM_fwd_rd = 0; MEM_fwd_RegWrite = 0; MEM_fwd_data = 0;
        WB_fwd_rd = 0; WB_fwd_RegWrite = 0; WB_fwd_data = 0;
    endtask

    initial begin
        m_valid = 0; m_rw = 0; m_mw = 0; m_mtr = 0;
        m_res = 0; m_sd = 0; m_rd = 0; m_cmem = 0; m_cwb = 0;

        idle(); rst = 1;
        step();
        chk("reset_valid", 32'(MEM_valid), 32'd0);
        chk("reset_result", MEM_ALUResult, 32'd0);

        // ADD, no hazard
        idle(); EX_valid = 1; EX_data1 = 5; EX_data2 = 7; EX_rs1 = 1; EX_rs2 = 2;
        EX_rd = 4; EX_RegWrite = 1;
        step();
        chk("add_result", MEM_ALUResult, 32'd12);
        chk("add_valid", 32'(MEM_valid), 32'd1);

        // MEM wins over WB for the same register
        idle(); EX_valid = 1; EX_rs1 = 3; EX_data1 = 0; EX_data2 = 1; EX_RegWrite = 1;
        MEM_fwd_rd = 3; MEM_fwd_RegWrite = 1; MEM_fwd_data = 32'hA;
        WB_fwd_rd = 3; WB_fwd_RegWrite = 1; WB_fwd_data = 32'hB;
        step();
        chk("mem_priority", MEM_ALUResult, 32'hB);
`ifdef EX_FWD_CNT_EN
        chk("cnt_mem_lit", 32'(fwd_mem_cnt), 32'd1);
        chk("cnt_wb_lit", 32'(fwd_wb_cnt), 32'd0);
`else
        chk("cnt_mem_tied", 32'(fwd_mem_cnt), 32'd0);
`endif

        // r0 is never forwarded
        idle(); EX_valid = 1; EX_rs2 = 0; EX_data2 = 0; EX_MemWrite = 1;
        MEM_fwd_rd = 0; MEM_fwd_RegWrite = 1; MEM_fwd_data = 32'hFF;
        step();
        chk("r0_store", MEM_StoreData, 32'd0);
        chk("r0_memwrite", 32'(MEM_MemWrite), 32'd1);

        // SUB wraps, immediate operand
        idle(); EX_valid = 1; EX_data1 = 0; EX_Imm = 1; EX_ALUScr = 1; EX_ALUControl = 2'b01;
        step();
        chk("sub_wrap", MEM_ALUResult, 32'hFFFF_FFFF);

        // XOR, stall twice, then stall+flush
        idle(); EX_valid = 1; EX_data1 = 32'hF0; EX_data2 = 32'h0F; EX_ALUControl = 2'b10;
        EX_RegWrite = 1; EX_MemWrite = 1; EX_rd = 5;
        step();
        chk("xor_result", MEM_ALUResult, 32'hFF);
        EX_data1 = 32'h1234; stall = 1;
        step();
        step();
        chk("stall_hold", MEM_ALUResult, 32'hFF);
        chk("stall_valid", 32'(MEM_valid), 32'd1);
        flush = 1;
        step();
        chk("flush_valid", 32'(MEM_valid), 32'd0);
        chk("flush_rw", 32'(MEM_RegWrite), 32'd0);
        chk("flush_mw", 32'(MEM_MemWrite), 32'd0);

        // Reset mid-stream during a stall
        idle(); EX_valid = 1; EX_data1 = 9; EX_data2 = 1; EX_RegWrite = 1; EX_rd = 7;
        step();
        stall = 1; rst = 1;
        step();
        chk("rst_over_stall", MEM_ALUResult, 32'd0);
        chk("rst_rd", 32'(MEM_rd), 32'd0);
        idle(); EX_valid = 1; EX_data1 = 2; EX_data2 = 3;
        step();
        chk("after_rst", MEM_ALUResult, 32'd5);

        // Randomized traffic with a small register range to provoke hazards
        for (int i = 0; i < 600; i++) begin
            rst   = ($urandom_range(0, 59) == 0);
            stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 9) == 0);
            EX_valid = ($urandom_range(0, 5) != 0);
            EX_data1 = $urandom; EX_data2 = $urandom; EX_Imm = $urandom;
            EX_rd = 4'($urandom_range(0, 15));
            EX_rs1 = 4'($urandom_range(0, 3));
            EX_rs2 = 4'($urandom_range(0, 3));
            EX_ALUControl = 2'($urandom_range(0, 3));
            EX_RegWrite = 1'($urandom); EX_MemWrite = 1'($urandom);
            EX_MemToReg = 1'($urandom); EX_ALUScr = 1'($urandom);
            MEM_fwd_rd = 4'($urandom_range(0, 3)); MEM_fwd_RegWrite = 1'($urandom);
            MEM_fwd_data = $urandom;
            WB_fwd_rd = 4'($urandom_range(0, 3)); WB_fwd_RegWrite = 1'($urandom);
            WB_fwd_data = $urandom;
            step();
        end

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
Execute stage directly downstream of the ID/EX pipeline register. It consumes the EX_* operand and control bundle and resolves RAW hazards by forwarding from the MEM and WB stages. It computes the ALU result and registers everything into the EX/MEM boundary. The boundary supports stall (hold), flush (bubble) and a valid bit, so the memory stage sees a clean, cycle-aligned bundle.

Parameters:
DATA_W, 32, operand/result width
REG_W, 4, register index width (16 architectural registers; r0 reads as zero and is never a forwarding source)

Ports:
clk  in  1  pipeline clock, all state updates on posedge
rst  in  1  synchronous active-high reset
EX_valid  in  1  ID/EX bundle holds a real instruction
EX_data1  in  DATA_W  rs1 value read in ID
EX_data2  in  DATA_W  rs2 value read in ID
EX_Imm  in  DATA_W  sign-extended immediate
EX_rd, EX_rs1, EX_rs2  in  REG_W  register indices
EX_ALUControl  in  2  00 ADD, 01 SUB, 10 XOR, 11 AND
EX_RegWrite, EX_MemWrite, EX_MemToReg, EX_ALUScr  in  1  control; ALUScr=1 selects Imm as operand B
MEM_fwd_rd  in  REG_W  destination of the instruction now in MEM
MEM_fwd_RegWrite  in  1  that instruction writes a register
MEM_fwd_data  in  DATA_W  its ALU result
WB_fwd_rd  in  REG_W  destination in WB
WB_fwd_RegWrite  in  1  WB writes a register
WB_fwd_data  in  DATA_W  final writeback value
stall  in  1  hold the EX/MEM register
flush  in  1  replace the captured instruction with a bubble
MEM_valid  out  1  registered valid
MEM_ALUResult  out  DATA_W  registered ALU result
MEM_StoreData  out  DATA_W  registered forwarded rs2 value
MEM_rd  out  REG_W  registered destination
MEM_RegWrite, MEM_MemWrite, MEM_MemToReg  out  1  registered control
fwd_mem_cnt, fwd_wb_cnt  out  16  forwarding event counters (see Optional Feature)

Behaviour:
- Reset: when rst=1 at a posedge, every output becomes 0. Reset overrides stall and flush.
- Forwarding per source operand (rs1 and rs2), evaluated independently:
  - If MEM_fwd_RegWrite and MEM_fwd_rd==rsX and rsX!=0, use MEM_fwd_data.
  - Else if WB_fwd_RegWrite and WB_fwd_rd==rsX and rsX!=0, use WB_fwd_data.
  - Else use EX_dataX.
  - MEM has priority over WB when both match.
- Operand A = forwarded rs1. Operand B = EX_Imm if EX_ALUScr, else forwarded rs2.
- StoreData is always the forwarded rs2, independent of ALUScr.
- ALU arithmetic:
  - ADD/SUB are modulo 2^DATA_W; carry and borrow are discarded.
  - XOR and AND are bitwise.
  - The ALU is purely combinational; the only latency is the EX/MEM register, so results appear exactly 1 cycle after the EX bundle is presented.
- Posedge update priority: rst > flush > stall > load.
  - flush: MEM_valid, MEM_RegWrite, MEM_MemWrite and MEM_MemToReg are cleared to 0; data fields are don't-care and are implemented as 0. flush wins over a simultaneous stall.
  - stall: all outputs hold their values.
  - load: all outputs capture the EX bundle and computed values.
    - If EX_valid=0, MEM_valid=0 and RegWrite/MemWrite are forced to 0, so invalid slots are never written.
- Forwarding state machine: none; forwarding is combinational from the current-cycle MEM/WB inputs. Upstream must not assert stall while it relies on a forwarding source that will advance.
- Bubble: an instruction with EX_RegWrite=1 and EX_rd=0 is loaded normally. Downstream ignores writes to r0.

Optional Feature:
- Macro: EX_FWD_CNT_EN.
- Defined:
  - fwd_mem_cnt increments by 1 per operand forwarded from MEM on a load cycle with EX_valid=1.
  - fwd_wb_cnt does the same for WB forwards.
  - Both rs1 and rs2 forwarded in one cycle increment by 2.
  - Counters saturate at 16'hFFFF, clear on rst, and hold during stall or flush cycles.
- Undefined: both ports are tied to 0 and no counter flops exist.

Decomposition:
- Package ex_pkg holds:
  - alu_op_e enum (ALU_ADD=2'b00, ALU_SUB=2'b01, ALU_XOR=2'b10, ALU_AND=2'b11)
  - fwd_sel_e enum (FWD_NONE, FWD_MEM, FWD_WB)
  - DATA_W and REG_W defaults
- Sub-module ex_forward_unit: combinational. It compares rs1/rs2 against the MEM/WB destinations and outputs two fwd_sel_e selects. It is instantiated once.

Test Plan:
- ADD no hazard: data1=5, data2=7, ALUScr=0, op=00, EX_valid=1 → next cycle MEM_ALUResult=12, MEM_valid=1.
- MEM forward priority: rs1=3, MEM_fwd_rd=3 with data 0xA, WB_fwd_rd=3 with data 0xB, EX_data1=0, data2=1, op=00 → MEM_ALUResult=0xB (0xA+1); with the counters macro, fwd_mem_cnt=1 and fwd_wb_cnt=0.
- r0 never forwarded: rs2=0, MEM_fwd_rd=0, MEM_fwd_RegWrite=1, MEM_fwd_data=0xFF, EX_data2=0, store instruction → MEM_StoreData=0.
- SUB wrap and Imm: data1=0, Imm=1, ALUScr=1, op=01 → MEM_ALUResult=0xFFFFFFFF.
- Stall then flush: load XOR 0xF0^0x0F, then stall 2 cycles → outputs hold 0xFF, valid=1; then stall=1 and flush=1 together → MEM_valid=0, MEM_RegWrite=0, MEM_MemWrite=0.
- Reset mid-stream: assert rst during a stall with valid data held → next cycle all outputs 0; after release, the first loaded instruction appears after 1 cycle.
